// File: rtl/rle_pkg.sv
// Shared run-length codec definitions: field widths, FSM state type, maximum run.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rle_pkg;

    localparam int VAL_W_DEF = 8;
    localparam int CNT_W_DEF = 8;

    // Longest run one pair can describe; the encoder splits longer runs here.
    localparam int CNT_MAX = (1 << CNT_W_DEF) - 1;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

endpackage

// File: rtl/rle_decoder.sv
// Expands (value, amount) pairs into a stream of repeated values, one per accepted beat.
// Latency: pair accepted at edge N presents its first beat right after edge N; runs chain with no bubble.
// Backpressure: beats hold while i_out_ready=0; o_in_ready rises only in IDLE or on the last-beat consume.
// Optional: define RLE_DEC_ERR_CHECK_EN to add sticky o_err, flagging accepted zero-amount pairs.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int VAL_W = VAL_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_valid,
    input  logic [VAL_W-1:0] i_val,
    input  logic [CNT_W-1:0] i_count,
    output logic             o_in_ready,
    output logic [VAL_W-1:0] o_val,
    output logic             o_valid,
    input  logic             i_out_ready,
    output logic             o_busy
`ifdef RLE_DEC_ERR_CHECK_EN
    ,
    output logic             o_err
`endif
);

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic             accept;
    logic             consume;
    logic             last_beat;
    logic             cnt_zero;

    // rem==1 only occurs in EXPAND, so the last-beat term implies a beat is being consumed.
    assign last_beat  = (rem == CNT_W'(1)) && i_out_ready;
    assign o_in_ready = (state == IDLE) || last_beat;
    assign accept     = i_valid && o_in_ready;
    assign consume    = o_valid && i_out_ready;
    assign cnt_zero   = (i_count == '0);
    assign o_busy     = o_valid;

    // Expansion FSM and down-counter; a new run overrides the finishing one for zero-bubble chaining.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            rem     <= '0;
            o_val   <= '0;
            o_valid <= 1'b0;
        end else if (accept && !cnt_zero) begin
            state   <= EXPAND;
            rem     <= i_count;
            o_val   <= i_val;
            o_valid <= 1'b1;
        end else if (consume && last_beat) begin
            // Run exhausted (a coincident zero-amount pair adds nothing); o_val keeps its last value.
            state   <= IDLE;
            rem     <= '0;
            o_valid <= 1'b0;
        end else if (consume) begin
            rem     <= rem - CNT_W'(1);
        end
    end

`ifdef RLE_DEC_ERR_CHECK_EN
    // Sticky flag for malformed zero-amount pairs; only reset clears it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            o_err <= 1'b0;
        end else if (accept && cnt_zero) begin
            o_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rle_decoder.sv
// Randomised and directed bench for rle_decoder against a beat-queue reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rle_decoder;

    logic       CLK;
    logic       RST;
    logic       i_valid;
    logic [7:0] i_val;
    logic [7:0] i_count;
    logic       o_in_ready;
    logic [7:0] o_val;
    logic       o_valid;
    logic       i_out_ready;
    logic       o_busy;
`ifdef RLE_DEC_ERR_CHECK_EN
    logic       o_err;
`endif

    rle_decoder #(.VAL_W(8), .CNT_W(8)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_valid     (i_valid),
        .i_val       (i_val),
        .i_count     (i_count),
        .o_in_ready  (o_in_ready),
        .o_val       (o_val),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy)
`ifdef RLE_DEC_ERR_CHECK_EN
        ,
        .o_err       (o_err)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: every beat still owed to downstream, in order.
    logic [7:0]  exp_q[$];
    logic [7:0]  last_val;
    logic        exp_err;
    logic [7:0]  got_q[$];
    logic [15:0] pq[$];
    logic [7:0]  stream[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check pre-edge outputs against the model, then advance the model.
    task automatic step(input logic v, input logic [7:0] val, input logic [7:0] cnt,
                        input logic r, output logic acc);
        logic exp_rdy;
        logic cons;
        @(negedge CLK);
        i_valid = v; i_val = val; i_count = cnt; i_out_ready = r;
        #1;
        exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
        chk("o_valid", {31'b0, o_valid}, {31'b0, exp_q.size() != 0});
        chk("o_val", {24'b0, o_val}, {24'b0, (exp_q.size() != 0) ? exp_q[0] : last_val});
        chk("o_in_ready", {31'b0, o_in_ready}, {31'b0, exp_rdy});
        chk("o_busy", {31'b0, o_busy}, {31'b0, exp_q.size() != 0});
`ifdef RLE_DEC_ERR_CHECK_EN
        chk("o_err", {31'b0, o_err}, {31'b0, exp_err});
`endif
        acc  = v && exp_rdy;
        cons = (exp_q.size() != 0) && r;
        if (cons) begin
            last_val = exp_q.pop_front();
            got_q.push_back(last_val);
        end
        if (acc) begin
            if (cnt == 8'd0) exp_err = 1'b1;
            for (int k = 0; k < int'(cnt); k++) exp_q.push_back(val);
        end
    endtask

    // Feed pq into the DUT until everything is accepted and drained.
    // mode 0: always ready, 1: ready toggles, 2: random ready.
    task automatic run(input int mode, input int gap_pct, input int bound);
        int   cyc;
        logic acc;
        logic r;
        logic v;
        cyc = 0;
        while ((pq.size() != 0 || exp_q.size() != 0) && cyc < bound) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = ($urandom_range(0, 99) < 70);
            endcase
            v = (pq.size() != 0) && ($urandom_range(0, 99) >= gap_pct);
            if (pq.size() != 0) step(v, pq[0][15:8], pq[0][7:0], r, acc);
            else                step(1'b0, 8'h00, 8'h00, r, acc);
            if (acc) void'(pq.pop_front());
            cyc++;
        end
        chk("run_within_bound", {31'b0, cyc < bound}, 32'd1);
    endtask

    task automatic chk_got(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, got_q.size(), exp.size());
        for (int k = 0; k < exp.size() && k < got_q.size(); k++)
            chk(tag, {24'b0, got_q[k]}, {24'b0, exp[k]});
        got_q.delete();
    endtask

    initial begin
        logic       acc;
        logic [7:0] e[$];
        int         n_aa;
        int         idx;
        int         c;
        logic [7:0] v8;

        RST = 1'b0; i_valid = 1'b0; i_val = '0; i_count = '0; i_out_ready = 1'b0;
        last_val = 8'h00; exp_err = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_o_valid", {31'b0, o_valid}, 32'd0);
        chk("reset_o_val", {24'b0, o_val}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Single run of three beats.
        pq.push_back({8'h3C, 8'd3});
        run(0, 0, 50);
        e = '{8'h3C, 8'h3C, 8'h3C};
        chk_got("single_run", e);

        // Back-to-back runs with no gap.
        pq.push_back({8'h10, 8'd2}); pq.push_back({8'h20, 8'd1}); pq.push_back({8'h30, 8'd4});
        run(0, 0, 50);
        e = '{8'h10, 8'h10, 8'h20, 8'h30, 8'h30, 8'h30, 8'h30};
        chk_got("chain", e);

        // Maximum-length run under alternating stall.
        pq.push_back({8'hAA, 8'd255});
        run(1, 0, 2000);
        n_aa = 0;
        foreach (got_q[k]) if (got_q[k] == 8'hAA) n_aa++;
        chk("max_run_len", got_q.size(), 32'd255);
        chk("max_run_all_aa", n_aa, 32'd255);
        got_q.delete();

        // Zero-amount pair is dropped.
        pq.push_back({8'h55, 8'd0}); pq.push_back({8'h66, 8'd1});
        run(0, 0, 50);
        e = '{8'h66};
        chk_got("zero_count", e);
`ifdef RLE_DEC_ERR_CHECK_EN
        step(1'b0, 8'h00, 8'h00, 1'b1, acc);
        chk("err_sticky", {31'b0, o_err}, 32'd1);
`endif

        // Asynchronous reset in the middle of a run.
        step(1'b1, 8'h77, 8'd5, 1'b1, acc);
        step(1'b0, 8'h00, 8'h00, 1'b1, acc);
        step(1'b0, 8'h00, 8'h00, 1'b1, acc);
        #2 RST = 1'b0;
        #1;
        chk("async_rst_o_valid", {31'b0, o_valid}, 32'd0);
        chk("async_rst_o_val", {24'b0, o_val}, 32'd0);
        exp_q.delete(); last_val = 8'h00; exp_err = 1'b0; got_q.delete();
        i_valid = 1'b1; i_val = 8'h99; i_count = 8'd2;
        @(posedge CLK);
        @(negedge CLK);
        i_valid = 1'b0;
        RST = 1'b1;
        repeat (3) step(1'b0, 8'h00, 8'h00, 1'b1, acc);
        chk("no_beats_after_rst", got_q.size(), 32'd0);
        pq.push_back({8'h01, 8'd1});
        run(0, 0, 50);
        e = '{8'h01};
        chk_got("after_rst", e);

        // Random round trip: build a stream, encode runs into pairs, decode under random stalls.
        for (int k = 0; k < 260; k++) stream.push_back(8'hEE);
        while (stream.size() < 560) begin
            v8 = 8'($urandom_range(0, 3) * 17);
            c  = $urandom_range(1, 6);
            for (int k = 0; k < c; k++) stream.push_back(v8);
        end
        idx = 0;
        while (idx < stream.size()) begin
            v8 = stream[idx];
            c  = 0;
            while (idx < stream.size() && stream[idx] == v8 && c < 255) begin
                c++; idx++;
            end
            pq.push_back({v8, 8'(c)});
        end
        run(2, 30, 8000);
        chk_got("round_trip", stream);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
